// File: rtl/div16_seq_pkg.sv
// Shared ALU definitions: datapath width, divider state encoding, word type.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    typedef logic [ALU_WIDTH-1:0] word_t;

endpackage

// File: rtl/div16_seq_if.sv
// Start/busy/done handshake between the execute stage and the sequential divider.
interface div16_seq_if import alu_pkg::*; #(
    parameter int unsigned WIDTH = ALU_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div16_seq_sub_borrow.sv
// Combinational a - b with borrow out; shared by the divider and the ALU SUB op.
module sub_borrow #(
    parameter int unsigned WIDTH = 16
) (
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div16_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
module div16_seq import alu_pkg::*; #(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    div16_seq_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] q_reg, q_nxt;
    logic [WIDTH-1:0] r_reg, r_nxt;
    logic [WIDTH-1:0] d_reg, d_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy_nxt, done_nxt, dbz_nxt;
    logic [WIDTH-1:0] quo_nxt, rem_nxt;

    logic [WIDTH-1:0] trial_low;
    logic [WIDTH-1:0] trial_diff;
    logic             low_borrow;
    logic             trial_borrow;

    // Shifted remainder is WIDTH+1 bits; its MSB is folded into the borrow below.
    assign trial_low = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};

    sub_borrow #(.WIDTH(WIDTH)) u_sub (
        .diff   (trial_diff),
        .borrow (low_borrow),
        .a      (trial_low),
        .b      (d_reg)
    );

    // A set MSB means the shifted remainder already exceeds any WIDTH-bit divisor.
    assign trial_borrow = ~r_reg[WIDTH-1] & low_borrow;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= DIV_IDLE;
            q_reg           <= '0;
            r_reg           <= '0;
            d_reg           <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            state           <= state_nxt;
            q_reg           <= q_nxt;
            r_reg           <= r_nxt;
            d_reg           <= d_nxt;
            cnt             <= cnt_nxt;
            bus.busy        <= busy_nxt;
            bus.done        <= done_nxt;
            bus.quotient    <= quo_nxt;
            bus.remainder   <= rem_nxt;
            bus.div_by_zero <= dbz_nxt;
        end
    end

    // Next-state, iteration step and next output values
    always_comb begin
        state_nxt = state;
        q_nxt     = q_reg;
        r_nxt     = r_reg;
        d_nxt     = d_reg;
        cnt_nxt   = cnt;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        quo_nxt   = bus.quotient;
        rem_nxt   = bus.remainder;
        dbz_nxt   = bus.div_by_zero;

        case (state)
            DIV_IDLE, DIV_DONE: begin
                if (bus.start) begin
                    q_nxt   = bus.dividend;
                    d_nxt   = bus.divisor;
                    r_nxt   = '0;
                    cnt_nxt = '0;
                    dbz_nxt = 1'b0;
                    if (bus.divisor == '0) begin
                        state_nxt = DIV_DONE;
                        done_nxt  = 1'b1;
                        quo_nxt   = '1;
                        rem_nxt   = bus.dividend;
                        dbz_nxt   = 1'b1;
                    end else begin
                        state_nxt = DIV_RUN;
                        busy_nxt  = 1'b1;
                    end
                end else begin
                    state_nxt = DIV_IDLE;
                end
            end

            DIV_RUN: begin
                busy_nxt = 1'b1;
                q_nxt    = {q_reg[WIDTH-2:0], ~trial_borrow};
                r_nxt    = trial_borrow ? trial_low : trial_diff;
                cnt_nxt  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = DIV_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    quo_nxt   = q_nxt;
                    rem_nxt   = r_nxt;
                end
            end

            default: state_nxt = DIV_IDLE;
        endcase
    end

endmodule

// File: tb/tb_div16_seq.sv
// Directed and back-to-back random checks of the sequential divider.
module tb_div16_seq;
    import alu_pkg::*;

    localparam int unsigned W = ALU_WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    div16_seq_if #(.WIDTH(W)) bus ();

    div16_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges after the current sample until done is seen, bounded
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
            if (bus.busy) busy_n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic edbz);
        int lat;
        int bn;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start = 1'b0;
        wait_done(lat, bn);
        check({tag, ".latency"}, 32'(lat), edbz ? 32'd0 : 32'(W));
        check({tag, ".busy_cycles"}, 32'(bn), edbz ? 32'd0 : 32'(W));
        check({tag, ".quotient"}, 32'(bus.quotient), 32'(eq));
        check({tag, ".remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, ".dbz"}, 32'(bus.div_by_zero), 32'(edbz));
        tick();
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int lat;
        int bn;
        int seen_done;
        logic [15:0] ca, cb, na, nb, eq, er;
        logic ed;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n        = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.quotient", 32'(bus.quotient), 32'd0);
        check("reset.remainder", 32'(bus.remainder), 32'd0);
        check("reset.dbz", 32'(bus.div_by_zero), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        run_op("t1_100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        run_op("t2_ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
        run_op("t2_ffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
        run_op("t2_3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
        run_op("t3_1234_0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
        run_op("t3_8_2", 16'd8, 16'd2, 16'd4, 16'd0, 1'b0);

        // Start pulse during RUN must be ignored
        bus.start    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 16'd5;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.start    = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor  = 16'd3;
        tick();
        bus.start = 1'b0;
        wait_done(lat, bn);
        check("t4.latency", 32'(lat), 32'(W - 5));
        check("t4.quotient", 32'(bus.quotient), 32'd10);
        check("t4.remainder", 32'(bus.remainder), 32'd0);
        check("t4.dbz", 32'(bus.div_by_zero), 32'd0);
        tick();

        // Asynchronous reset in the middle of RUN
        bus.start    = 1'b1;
        bus.dividend = 16'd7;
        bus.divisor  = 16'd2;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        check("t5.busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5.busy", 32'(bus.busy), 32'd0);
        check("t5.done", 32'(bus.done), 32'd0);
        check("t5.quotient", 32'(bus.quotient), 32'd0);
        check("t5.remainder", 32'(bus.remainder), 32'd0);
        check("t5.dbz", 32'(bus.div_by_zero), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 2) rst_n = 1'b1;
            if (bus.done) seen_done++;
        end
        check("t5.no_done", 32'(seen_done), 32'd0);
        run_op("t5_20_6", 16'd20, 16'd6, 16'd3, 16'd2, 1'b0);

        // Back-to-back ops with start held high
        ca = 16'($urandom);
        cb = 16'd0;
        bus.start    = 1'b1;
        bus.dividend = ca;
        bus.divisor  = cb;
        tick();
        for (int i = 0; i < 1000; i++) begin
            wait_done(lat, bn);
            if (cb == 16'd0) begin
                eq = 16'hFFFF;
                er = ca;
                ed = 1'b1;
            end else begin
                eq = ca / cb;
                er = ca % cb;
                ed = 1'b0;
            end
            check("t6.latency", 32'(lat), ed ? 32'd0 : 32'(W));
            check("t6.quotient", 32'(bus.quotient), 32'(eq));
            check("t6.remainder", 32'(bus.remainder), 32'(er));
            check("t6.dbz", 32'(bus.div_by_zero), 32'(ed));
            na = 16'($urandom);
            if (i % 8 == 7)      nb = 16'd0;
            else if (i % 3 == 0) nb = 16'($urandom_range(1, 15));
            else                 nb = 16'($urandom);
            if (i == 999) begin
                bus.start = 1'b0;
            end else begin
                bus.dividend = na;
                bus.divisor  = nb;
            end
            ca = na;
            cb = nb;
            tick();
        end
        check("t6.idle_done", 32'(bus.done), 32'd0);
        check("t6.idle_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
